// File: rtl/sa_result_drain.sv
// Captures a 4x4 tile of 32-bit array results on start and drains the valid sub-tile
// one word per handshake, in row- or column-major order, with index and last tags.
module sa_result_drain #(
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] ans,
  input  logic [1:0]   rows_m1,
  input  logic [1:0]   cols_m1,
  output logic         acc_clear,
  output logic [31:0]  out_data,
  output logic [1:0]   out_row,
  output logic [1:0]   out_col,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t       state_q, state_d;
  logic [511:0] data_q, data_d;
  logic [1:0]   rows_q, rows_d;
  logic [1:0]   cols_q, cols_d;
  logic [1:0]   r_q, r_d;
  logic [1:0]   c_q, c_d;
  logic         acc_clear_q, acc_clear_d;
  logic         done_q, done_d;

  logic         at_last;
  logic [8:0]   word_idx;

  assign at_last  = (r_q == rows_q) && (c_q == cols_q);
  // r*128 + (3-c)*32; for a 2-bit c, 3-c is simply ~c
  assign word_idx = {r_q, ~c_q, 5'b0};

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    r_d         = r_q;
    c_d         = c_q;
    acc_clear_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d      = ans;
          rows_d      = rows_m1;
          cols_d      = cols_m1;
          r_d         = 2'd0;
          c_d         = 2'd0;
          acc_clear_d = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (COL_MAJOR) begin
            if (r_q == rows_q) begin
              r_d = 2'd0;
              c_d = c_q + 2'd1;
            end else begin
              r_d = r_q + 2'd1;
            end
          end else begin
            if (c_q == cols_q) begin
              c_d = 2'd0;
              r_d = r_q + 2'd1;
            end else begin
              c_d = c_q + 2'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      rows_q      <= 2'd0;
      cols_q      <= 2'd0;
      r_q         <= 2'd0;
      c_q         <= 2'd0;
      acc_clear_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      r_q         <= r_d;
      c_q         <= c_d;
      acc_clear_q <= acc_clear_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && at_last;
  assign out_data  = data_q[word_idx +: 32];
  assign out_row   = r_q;
  assign out_col   = c_q;
  assign acc_clear = acc_clear_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Bench for sa_result_drain: one row-major and one column-major instance, scoreboarded.
module tb_sa_result_drain;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   st;
  logic [511:0] ans;
  logic [1:0]   rows_m1, cols_m1;
  logic         out_ready;
  logic [1:0]   acc, vld, lst, bsy, dn;
  logic [31:0]  od [2];
  logic [1:0]   orw [2];
  logic [1:0]   ocl [2];

  sa_result_drain #(.COL_MAJOR(1'b0)) u_rm (
    .clk(clk), .rst(rst), .start(st[0]), .ans(ans), .rows_m1(rows_m1), .cols_m1(cols_m1),
    .acc_clear(acc[0]), .out_data(od[0]), .out_row(orw[0]), .out_col(ocl[0]),
    .out_valid(vld[0]), .out_ready(out_ready), .out_last(lst[0]), .busy(bsy[0]), .done(dn[0])
  );

  sa_result_drain #(.COL_MAJOR(1'b1)) u_cm (
    .clk(clk), .rst(rst), .start(st[1]), .ans(ans), .rows_m1(rows_m1), .cols_m1(cols_m1),
    .acc_clear(acc[1]), .out_data(od[1]), .out_row(orw[1]), .out_col(ocl[1]),
    .out_valid(vld[1]), .out_ready(out_ready), .out_last(lst[1]), .busy(bsy[1]), .done(dn[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // expected entry: {data, row, col, last}
  logic [36:0] q0[$];
  logic [36:0] q1[$];
  int          hs_cnt [2]   = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          acc_cnt [2]  = '{0, 0};
  logic [1:0]  stall_q = 2'b00;
  logic [36:0] held [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [36:0] cur, e;
      cur = {od[d], orw[d], ocl[d], lst[d]};
      if (dn[d]) done_cnt[d]++;
      if (acc[d]) acc_cnt[d]++;
      if (stall_q[d] && vld[d]) chk($sformatf("stable%0d", d), cur, held[d]);
      if (vld[d] && out_ready) begin
        hs_cnt[d]++;
        e = 'x;
        if (d == 0) begin
          if (q0.size() != 0) e = q0.pop_front();
        end else begin
          if (q1.size() != 0) e = q1.pop_front();
        end
        chk($sformatf("word%0d", d), cur, e);
      end
      stall_q[d] = vld[d] && !out_ready;
      held[d]    = cur;
    end
  end

  function automatic logic [511:0] build(input logic [31:0] base);
    logic [511:0] a;
    a = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        a[i*128 + (3-j)*32 +: 32] = base + 32'h100 * i + j;
    return a;
  endfunction

  task automatic push_exp(input int d, input logic [31:0] base, input logic [1:0] rm, input logic [1:0] cm);
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        int r, c;
        logic [36:0] e;
        r = (d == 1) ? b : a;
        c = (d == 1) ? a : b;
        if (r <= int'(rm) && c <= int'(cm)) begin
          e = {base + 32'h100 * r + c, 2'(r), 2'(c), (r == int'(rm)) && (c == int'(cm))};
          if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
  endtask

  // caller is aligned at posedge+1; returns aligned the same way, one edge later
  task automatic start_tile(input int d, input logic [31:0] base, input logic [1:0] rm,
                            input logic [1:0] cm, input bit push);
    ans     = build(base);
    rows_m1 = rm;
    cols_m1 = cm;
    st[d]   = 1'b1;
    if (push) push_exp(d, base, rm, cm);
    @(posedge clk);
    #1;
    st[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget, input bit bp, output int cyc);
    cyc = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (dn[d]) return;
      if (bp) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    end
    chk($sformatf("done_timeout%0d", d), dn[d], 1);
  endtask

  int cyc, h, a, dc;

  initial begin
    rst = 1'b0; st = 2'b00; ans = '0; rows_m1 = 2'd0; cols_m1 = 2'd0; out_ready = 1'b1;
    #3;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ctrl%0d", d), {vld[d], bsy[d], dn[d], acc[d], lst[d]}, 0);
      chk($sformatf("rst_data%0d", d), {od[d], orw[d], ocl[d]}, 0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // full row-major tile, no backpressure
    h = hs_cnt[0]; a = acc_cnt[0];
    start_tile(0, 32'h0, 2'd3, 2'd3, 1'b1);
    chk("t1_acc_clear", acc[0], 1);
    chk("t1_first", {vld[0], orw[0], ocl[0], od[0]}, {1'b1, 2'd0, 2'd0, 32'h0});
    wait_done(0, 100, 1'b0, cyc);
    chk("t1_latency", cyc, 16);
    chk("t1_words", hs_cnt[0] - h, 16);
    @(posedge clk);
    #1;
    chk("t1_idle", {vld[0], bsy[0], dn[0]}, 0);
    chk("t1_acc_pulses", acc_cnt[0] - a, 1);

    // backpressure 1,0,0,1,...
    h = hs_cnt[0];
    start_tile(0, 32'h1000_0000, 2'd3, 2'd3, 1'b1);
    wait_done(0, 200, 1'b1, cyc);
    out_ready = 1'b1;
    chk("t2_words", hs_cnt[0] - h, 16);
    chk("t2_stalled", cyc > 16, 1);

    // partial tile
    h = hs_cnt[0];
    start_tile(0, 32'h2000_0000, 2'd1, 2'd2, 1'b1);
    wait_done(0, 100, 1'b0, cyc);
    chk("t3_words", hs_cnt[0] - h, 6);
    chk("t3_latency", cyc, 6);

    // column-major full tile
    h = hs_cnt[1];
    start_tile(1, 32'h3000_0000, 2'd3, 2'd3, 1'b1);
    wait_done(1, 100, 1'b0, cyc);
    chk("t4_words", hs_cnt[1] - h, 16);

    // start mid-drain ignored, then start in the done cycle
    h = hs_cnt[0]; a = acc_cnt[0];
    start_tile(0, 32'h4000_0000, 2'd3, 2'd3, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    start_tile(0, 32'h5000_0000, 2'd1, 2'd1, 1'b0);
    wait_done(0, 100, 1'b0, cyc);
    chk("t5_words", hs_cnt[0] - h, 16);
    chk("t5_acc_pulses", acc_cnt[0] - a, 1);
    start_tile(0, 32'h6000_0000, 2'd2, 2'd1, 1'b1);
    chk("t5_back2back", {vld[0], orw[0], ocl[0], od[0]}, {1'b1, 2'd0, 2'd0, 32'h6000_0000});
    wait_done(0, 100, 1'b0, cyc);

    // reset mid-drain
    h = hs_cnt[0];
    start_tile(0, 32'h7000_0000, 2'd3, 2'd3, 1'b1);
    for (int k = 0; k < 50 && (hs_cnt[0] - h) < 5; k++) begin @(posedge clk); #1; end
    chk("t6_reached5", hs_cnt[0] - h, 5);
    dc = done_cnt[0];
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_ctrl", {vld[0], bsy[0], dn[0], acc[0], lst[0]}, 0);
    chk("t6_rst_data", {od[0], orw[0], ocl[0]}, 0);
    q0.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_done", done_cnt[0] - dc, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    h = hs_cnt[0];
    start_tile(0, 32'h8000_0000, 2'd3, 2'd3, 1'b1);
    wait_done(0, 100, 1'b0, cyc);
    chk("t6_words", hs_cnt[0] - h, 16);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_left0", q0.size(), 0);
    chk("sb_left1", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sa_result_drain.md
SA_RESULT_DRAIN -- requirements
Module: sa_result_drain

Interface
REQ-001 Parameter: COL_MAJOR, default 0, drain order: 0 = row-major, 1 = column-major.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse: array results valid on ans; capture and drain.
REQ-005 ans  input  512  4x4 array results, 32-bit each; PE(row i, col j) at bits [i*128+(3-j)*32 +: 32].
REQ-006 rows_m1  input  2  valid tile rows minus 1, sampled with start.
REQ-007 cols_m1  input  2  valid tile cols minus 1, sampled with start.
REQ-008 acc_clear  output  1  one-cycle pulse telling the array to clear its accumulators.
REQ-009 out_data  output  32  current result word.
REQ-010 out_row  output  2  row index of out_data.
REQ-011 out_col  output  2  column index of out_data.
REQ-012 out_valid  output  1  out_data/out_row/out_col/out_last valid.
REQ-013 out_ready  input  1  consumer accepts the word when out_valid && out_ready.
REQ-014 out_last  output  1  high with the final word of the tile.
REQ-015 busy  output  1  high while in DRAIN.
REQ-016 done  output  1  one-cycle pulse after the final handshake.

Function
REQ-017 FSM states: IDLE, DRAIN; no other states.
REQ-018 IDLE + start=1 at edge: latch all 512 ans bits, rows_m1, cols_m1; zero row/col counters; go to DRAIN; acc_clear=1 for exactly the next cycle.
REQ-019 start is ignored while in DRAIN; captured data and counters are not disturbed.
REQ-020 Latency: out_valid=1 in the first cycle after the start edge, presenting row 0, col 0.
REQ-021 out_data = captured word at bits [r*128+(3-c)*32 +: 32] for current (r,c); out_row=r, out_col=c.
REQ-022 While out_valid && !out_ready, out_data, out_row, out_col and out_last stay stable; out_valid stays 1.
REQ-023 Handshake advances one word per cycle; sustained out_ready=1 gives one word per cycle with no bubbles.
REQ-024 COL_MAJOR=0: c increments first; c wraps to 0 after cols_m1 and r increments. COL_MAJOR=1: r first, wraps after rows_m1, then c increments.
REQ-025 Words drained per tile = (rows_m1+1)*(cols_m1+1), range 1..16; indices beyond the latched sizes are never emitted.
REQ-026 out_last = 1 exactly when r==rows_m1 && c==cols_m1 (latched values).
REQ-027 Handshake with out_last=1: next cycle state=IDLE, out_valid=0, busy=0, done=1 for one cycle.
REQ-028 start may be accepted in the done cycle (state already IDLE); the tile drains with no extra idle cycle.
REQ-029 Later changes to ans, rows_m1 or cols_m1 do not affect a tile already captured.
REQ-030 busy = 1 exactly while state = DRAIN.

Reset
REQ-031 rst=0 forces immediately, independent of clk: state=IDLE; out_valid, out_last, busy, done, acc_clear = 0; out_data=0; out_row=0; out_col=0; counters and captured data = 0.
REQ-032 Reset mid-drain discards the tile; no done pulse; the first start after rst=1 is handled normally.

Verification
REQ-033 Full tile, COL_MAJOR=0, rows_m1=cols_m1=3, PE(i,j)=0x100*i+j, out_ready=1 -> 16 words 0x000,0x001,...,0x303 on consecutive cycles; out_last on word 16; done one cycle later; acc_clear pulses once, in the cycle after start.
REQ-034 Backpressure: out_ready toggles 1,0,0,1,... -> no word dropped or duplicated; outputs stable during stall cycles; 16 handshakes total.
REQ-035 Partial tile rows_m1=1, cols_m1=2 -> words (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); out_last on (1,2); no (2,x) or (x,3) word emitted.
REQ-036 COL_MAJOR=1, full tile -> order (0,0),(1,0),(2,0),(3,0),(0,1),...,(3,3).
REQ-037 start pulsed mid-drain with new ans -> ignored; original data completes. Then start in the done cycle -> second tile's first word appears the next cycle.
REQ-038 rst=0 asserted after word 5 -> all outputs 0 immediately; no done pulse; a fresh start then drains a full correct tile.
